// File: rtl/stack_cpu_core.sv
// stack_cpu_core: parametrised stack-machine core.
//
// One instruction per cycle while running. The core keeps an instruction
// pointer, a carry flag, the top-of-stack register T and a data stack below T,
// and tracks how many stack entries are live. Instructions come from an
// external combinational ROM. The OUT instruction stalls the core until the
// sink accepts the word. Overflow, underflow and illegal opcodes stop the core
// and latch a fault code until reset.
//
// Instruction word (WIDTH+2 bits): [WIDTH+1:WIDTH] type, [WIDTH-1:0] imm,
// imm[3:0] subop.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   o_pc         program ROM address (the instruction pointer)
//   i_instr      instruction at o_pc, valid in the same cycle
//   o_out_data   output port data
//   o_out_valid  o_out_data is valid
//   i_out_ready  sink accepts the output word
//   o_depth      number of live stack entries (T included)
//   o_carry      carry flag
//   o_halted     core executed HALT
//   o_fault      0 none, 1 overflow, 2 underflow, 3 illegal opcode
//   o_retired    completed-instruction count (only with STACK_CPU_PERF_EN)
//
// Optional feature: define STACK_CPU_PERF_EN to add the o_retired counter.
module stack_cpu_core #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 16,
  parameter int PC_WIDTH    = 8
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  output logic [PC_WIDTH-1:0]              o_pc,
  input  logic [WIDTH+1:0]                 i_instr,
  output logic [WIDTH-1:0]                 o_out_data,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
  output logic                             o_carry,
  output logic                             o_halted,
  output logic [1:0]                       o_fault
`ifdef STACK_CPU_PERF_EN
  ,
  output logic [31:0]                      o_retired
`endif
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int AN = 1 << AW;

  typedef enum logic [1:0] {RUN, OUT_WAIT, HALT, FAULT} state_t;

  state_t              state_reg;
  logic [PC_WIDTH-1:0] ip_reg;
  logic [WIDTH-1:0]    t_reg;
  logic [DW-1:0]       depth_reg;
  logic                carry_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic                out_valid_reg;
  logic                halted_reg;
  logic [1:0]          fault_reg;
`ifdef STACK_CPU_PERF_EN
  logic [31:0]         retired_reg;
`endif

  // Entries below T. Slot depth-2 holds S; slot AN-1 is never live, so the
  // harmless write of a stale T on a push from an empty stack lands there.
  logic [WIDTH-1:0] stack_mem [0:AN-1];

  logic [1:0]       op_type;
  logic [WIDTH-1:0] imm;
  logic [3:0]       subop;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    s_idx;
  logic [WIDTH-1:0] s_val;

  assign op_type = i_instr[WIDTH+1:WIDTH];
  assign imm     = i_instr[WIDTH-1:0];
  assign subop   = imm[3:0];
  assign top_idx = depth_reg[AW-1:0] - AW'(1);
  assign s_idx   = depth_reg[AW-1:0] - AW'(2);
  // S is needed in the same cycle as decode, so the stack is read asynchronously.
  assign s_val   = stack_mem[s_idx];

  logic [1:0]          need;
  logic                push;
  logic                pop;
  logic                illegal;
  logic                do_out;
  logic                do_halt;
  logic [WIDTH-1:0]    t_next;
  logic                carry_next;
  logic [PC_WIDTH-1:0] ip_next;
  logic [DW-1:0]       depth_next;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [WIDTH:0]      sum;
  logic [1:0]          fault_code;
  logic                commit;

  always_comb begin
    need       = 2'd0;
    push       = 1'b0;
    pop        = 1'b0;
    illegal    = 1'b0;
    do_out     = 1'b0;
    do_halt    = 1'b0;
    t_next     = t_reg;
    carry_next = carry_reg;
    ip_next    = ip_reg + PC_WIDTH'(1);
    mem_we     = 1'b0;
    mem_addr   = top_idx;
    sum        = '0;
    case (op_type)
      2'b00: begin
        push   = 1'b1;
        mem_we = 1'b1;
        t_next = imm;
      end
      2'b01: begin
        need = 2'd2;
        pop  = 1'b1;
        case (subop)
          4'd0: begin
            sum        = {1'b0, s_val} + {1'b0, t_reg};
            t_next     = sum[WIDTH-1:0];
            carry_next = sum[WIDTH];
          end
          4'd1: begin
            // The extra top bit of the difference is the borrow (S < T).
            sum        = {1'b0, s_val} - {1'b0, t_reg};
            t_next     = sum[WIDTH-1:0];
            carry_next = sum[WIDTH];
          end
          4'd2:    t_next = s_val & t_reg;
          4'd3:    t_next = s_val | t_reg;
          4'd4:    t_next = s_val ^ t_reg;
          4'd5: begin
            sum        = {1'b0, s_val} + {1'b0, t_reg} + {{WIDTH{1'b0}}, carry_reg};
            t_next     = sum[WIDTH-1:0];
            carry_next = sum[WIDTH];
          end
          default: illegal = 1'b1;
        endcase
      end
      2'b10: ip_next = imm[PC_WIDTH-1:0];
      default: begin
        case (subop)
          4'd0: ;
          4'd1: begin
            need   = 2'd1;
            push   = 1'b1;
            mem_we = 1'b1;
          end
          4'd2: begin
            need   = 2'd1;
            pop    = 1'b1;
            t_next = s_val;
          end
          4'd3: begin
            need     = 2'd2;
            mem_we   = 1'b1;
            mem_addr = s_idx;
            t_next   = s_val;
          end
          4'd4: begin
            need   = 2'd1;
            pop    = 1'b1;
            t_next = s_val;
            if (t_reg == '0) ip_next = ip_reg + PC_WIDTH'(2);
          end
          4'd5: begin
            need   = 2'd1;
            pop    = 1'b1;
            t_next = s_val;
            do_out = 1'b1;
          end
          4'd15:   do_halt = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
    endcase

    if (illegal)                                     fault_code = 2'd3;
    else if (depth_reg < DW'(need))                  fault_code = 2'd2;
    else if (push && depth_reg == DW'(STACK_DEPTH))  fault_code = 2'd1;
    else                                             fault_code = 2'd0;

    if (push)     depth_next = depth_reg + DW'(1);
    else if (pop) depth_next = depth_reg - DW'(1);
    else          depth_next = depth_reg;
  end

  // An instruction changes architectural state only if it neither faults nor halts.
  assign commit = (state_reg == RUN) && (fault_code == 2'd0) && !do_halt;

  always_ff @(posedge i_clock) begin
    if (commit && mem_we) stack_mem[mem_addr] <= t_reg;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= RUN;
      ip_reg        <= '0;
      t_reg         <= '0;
      depth_reg     <= '0;
      carry_reg     <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
      fault_reg     <= 2'd0;
`ifdef STACK_CPU_PERF_EN
      retired_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        RUN: begin
          if (fault_code != 2'd0) begin
            state_reg <= FAULT;
            fault_reg <= fault_code;
          end else if (do_halt) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
`ifdef STACK_CPU_PERF_EN
            retired_reg <= retired_reg + 32'd1;
`endif
          end else begin
            ip_reg    <= ip_next;
            t_reg     <= t_next;
            carry_reg <= carry_next;
            depth_reg <= depth_next;
            if (do_out) begin
              out_data_reg  <= t_reg;
              out_valid_reg <= 1'b1;
              state_reg     <= OUT_WAIT;
            end
`ifdef STACK_CPU_PERF_EN
            else retired_reg <= retired_reg + 32'd1;
`endif
          end
        end
        OUT_WAIT: begin
          if (out_valid_reg && i_out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= RUN;
`ifdef STACK_CPU_PERF_EN
            retired_reg   <= retired_reg + 32'd1;
`endif
          end
        end
        HALT:  ;
        FAULT: ;
      endcase
    end
  end

  assign o_pc        = ip_reg;
  assign o_out_data  = out_data_reg;
  assign o_out_valid = out_valid_reg;
  assign o_depth     = depth_reg;
  assign o_carry     = carry_reg;
  assign o_halted    = halted_reg;
  assign o_fault     = fault_reg;
`ifdef STACK_CPU_PERF_EN
  assign o_retired   = retired_reg;
`endif

endmodule
